// File: rtl/hmc_arb_pkg.sv
// hmc_arb_pkg: shared HMC command encodings, widths and port-index helper
package hmc_arb_pkg;
  localparam int ADDR_WIDTH = 34;
  localparam int CMD_WIDTH = 4;
  localparam int SIZE_WIDTH = 4;
  typedef enum logic [CMD_WIDTH-1:0] {
    HMC_CMD_NOP     = 4'h0,
    HMC_CMD_WR      = 4'h1,
    HMC_CMD_PWR     = 4'h2,
    HMC_CMD_RD      = 4'h3,
    HMC_CMD_ATOMIC  = 4'h4,
    HMC_CMD_MODE_RD = 4'h5,
    HMC_CMD_MODE_WR = 4'h6,
    HMC_CMD_FLUSH   = 4'h7
  } hmc_cmd_e;
  function automatic int port_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hmc_rr_arbiter.sv
// hmc_rr_arbiter: N-way round-robin grant with a rotating priority pointer
module hmc_rr_arbiter
  import hmc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = port_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);
  logic [PW-1:0] ptr;
  int            best;
  // pick the requester closest to ptr going upward with wrap
  always_comb begin
    best = N;
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (en && req[j] && ((j - int'(ptr) + N) % N) < best) begin
        best = (j - int'(ptr) + N) % N;
        gnt_idx = PW'(j);
      end
    end
    gnt_valid = best < N;
    gnt = gnt_valid ? (N'(1) << gnt_idx) : '0;
  end
  // pointer moves past the winner; unchanged when nobody is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (gnt_valid) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/hmc_cmd_arbiter.sv
// hmc_cmd_arbiter: round-robin HMC command sharing with tag-owner tracking and per-port throttling
module hmc_cmd_arbiter
  import hmc_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ID_WIDTH        = 6,
  parameter int MAX_OUTSTANDING = 16,
  parameter int PORT_W          = 3,
  parameter int CNT_W           = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CMD_WIDTH*NUM_PORTS-1:0]   req_cmd,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr,
  input  logic [SIZE_WIDTH*NUM_PORTS-1:0]  req_size,
  input  logic [NUM_PORTS-1:0]             req_rsp,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [CMD_WIDTH-1:0]             cmd_out,
  output logic [ADDR_WIDTH-1:0]            addr_out,
  output logic [SIZE_WIDTH-1:0]            size_out,
  output logic                             cmd_valid_out,
  input  logic                             cmd_ready_out,
  input  logic [ID_WIDTH-1:0]              rd_data_tag,
  input  logic                             rd_data_valid,
  output logic [PORT_W-1:0]                rsp_port,
  output logic                             rsp_valid,
  output logic [CNT_W*NUM_PORTS-1:0]       outstanding,
  output logic                             err_underflow
);
  logic                  load_ok;
  logic                  gnt_valid;
  logic                  gnt_rsp;
  logic [PORT_W-1:0]     gnt_idx;
  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  gnt;
  logic [NUM_PORTS-1:0]  inc;
  logic [NUM_PORTS-1:0]  hit;
  logic [NUM_PORTS-1:0]  dec;
  logic [NUM_PORTS-1:0]  under;
  logic [CNT_W-1:0]      cnt [NUM_PORTS];
  logic [PORT_W-1:0]     owner [2**ID_WIDTH];
  logic [ID_WIDTH-1:0]   mirror_tag;
  logic [PORT_W-1:0]     rd_owner;
  logic [CMD_WIDTH-1:0]  sel_cmd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SIZE_WIDTH-1:0] sel_size;

  assign load_ok   = ~cmd_valid_out | cmd_ready_out;
  assign req_ready = gnt;
  assign gnt_rsp   = |(gnt & req_rsp);
  assign rd_owner  = owner[rd_data_tag];

  genvar i;
  generate
    for (i = 0; i < NUM_PORTS; i++) begin : g_port
      assign elig[i] = req_valid[i] & (~req_rsp[i] | (cnt[i] < CNT_W'(MAX_OUTSTANDING)));
      assign outstanding[i*CNT_W +: CNT_W] = cnt[i];
    end
  endgenerate

  hmc_rr_arbiter #(
    .N  (NUM_PORTS),
    .PW (PORT_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (load_ok),
    .req       (elig),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // one-hot payload mux of the granted port
  always_comb begin
    sel_cmd = '0;
    sel_addr = '0;
    sel_size = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (gnt[j]) begin
        sel_cmd = req_cmd[CMD_WIDTH*j +: CMD_WIDTH];
        sel_addr = req_addr[ADDR_WIDTH*j +: ADDR_WIDTH];
        sel_size = req_size[SIZE_WIDTH*j +: SIZE_WIDTH];
      end
    end
  end

  // per-port counter events; a response to an empty counter is an underflow, not a decrement
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      inc[j] = gnt[j] & req_rsp[j];
      hit[j] = rd_data_valid & (rd_owner == PORT_W'(j));
      dec[j] = hit[j] & (cnt[j] != '0);
      under[j] = hit[j] & (cnt[j] == '0);
    end
  end

  // output stage: reload whenever empty or being drained, otherwise hold payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_out <= 1'b0;
      cmd_out <= '0;
      addr_out <= '0;
      size_out <= '0;
    end else if (load_ok) begin
      cmd_valid_out <= gnt_valid;
      if (gnt_valid) begin
        cmd_out <= sel_cmd;
        addr_out <= sel_addr;
        size_out <= sel_size;
      end
    end
  end

  // owner table is plain distributed RAM: every entry is written before it is looked up
  always_ff @(posedge clk) begin
    if (gnt_rsp) owner[mirror_tag] <= gnt_idx;
  end

  // mirror of the tag manager's sequential allocator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mirror_tag <= '0;
    else if (gnt_rsp) mirror_tag <= mirror_tag + 1'b1;
  end

  // in-flight counters and sticky underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_PORTS; j++) cnt[j] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) cnt[j] <= cnt[j] + CNT_W'(inc[j]) - CNT_W'(dec[j]);
      err_underflow <= err_underflow | (|under);
    end
  end

  // response steering, one cycle after the tag arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_port <= '0;
    end else begin
      rsp_valid <= rd_data_valid;
      if (rd_data_valid) rsp_port <= rd_owner;
    end
  end
endmodule

// File: tb/tb_hmc_cmd_arbiter.sv
// tb_hmc_cmd_arbiter: directed and random checks of hmc_cmd_arbiter against a behavioural model
module tb_hmc_cmd_arbiter;
  import hmc_arb_pkg::*;
  localparam int NP = 4, IW = 6, MAXO = 2, PW = 3, CW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4*NP-1:0]  req_cmd = '0;
  logic [34*NP-1:0] req_addr = '0;
  logic [4*NP-1:0]  req_size = '0;
  logic [NP-1:0]    req_rsp = '0;
  logic [NP-1:0]    req_valid = '0;
  logic [NP-1:0]    req_ready;
  logic [3:0]       cmd_out;
  logic [33:0]      addr_out;
  logic [3:0]       size_out;
  logic             cmd_valid_out;
  logic             cmd_ready_out = 1'b1;
  logic [IW-1:0]    rd_data_tag = '0;
  logic             rd_data_valid = 1'b0;
  logic [PW-1:0]    rsp_port;
  logic             rsp_valid;
  logic [CW*NP-1:0] outstanding;
  logic             err_underflow;

  hmc_cmd_arbiter #(
    .NUM_PORTS(NP), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .PORT_W(PW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_cmd(req_cmd), .req_addr(req_addr), .req_size(req_size),
    .req_rsp(req_rsp), .req_valid(req_valid), .req_ready(req_ready), .cmd_out(cmd_out),
    .addr_out(addr_out), .size_out(size_out), .cmd_valid_out(cmd_valid_out),
    .cmd_ready_out(cmd_ready_out), .rd_data_tag(rd_data_tag), .rd_data_valid(rd_data_valid),
    .rsp_port(rsp_port), .rsp_valid(rsp_valid), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_ptr, m_tag, m_rp, rsp_grants;
  int m_own [64];
  int m_cnt [NP];
  bit m_err, m_cv, m_rv;
  logic [3:0]  m_cmd, m_size;
  logic [33:0] m_addr;
  logic [NP-1:0] obs_ready;
  int inflight [$];
  int order [5] = '{0, 1, 2, 3, 0};
  logic [33:0] saved_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_tag = 0; m_rp = 0; m_err = 0; m_cv = 0; m_rv = 0;
    m_cmd = '0; m_size = '0; m_addr = '0;
    for (int k = 0; k < NP; k++) m_cnt[k] = 0;
    inflight.delete();
  endtask

  task automatic check_regs();
    chk("cmd_valid_out", cmd_valid_out, m_cv);
    chk("cmd_out", cmd_out, m_cmd);
    chk("addr_out", addr_out, m_addr);
    chk("size_out", size_out, m_size);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_port", rsp_port, m_rp);
    chk("err_underflow", err_underflow, m_err);
    for (int k = 0; k < NP; k++) chk("outstanding", outstanding[k*CW +: CW], m_cnt[k]);
  endtask

  task automatic idle();
    req_valid = '0; req_rsp = '0; rd_data_valid = 1'b0; rd_data_tag = '0; cmd_ready_out = 1'b1;
  endtask

  task automatic set_port(input int p, input bit rsp);
    req_valid[p] = 1'b1;
    req_rsp[p] = rsp;
    req_cmd[4*p +: 4] = 4'($urandom);
    req_size[4*p +: 4] = 4'($urandom);
    req_addr[34*p +: 34] = 34'({$urandom, $urandom});
  endtask

  task automatic respond(input int tag);
    rd_data_valid = 1'b1;
    rd_data_tag = IW'(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_cmd_valid", cmd_valid_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_rsp_port", rsp_port, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_regs();
  endtask

  // one clock: predict grant from the rules, compare, then advance the model and compare registers
  task automatic cycle();
    int g, o, p;
    bit lok;
    @(negedge clk);
    lok = !m_cv || cmd_ready_out;
    g = -1;
    if (lok) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (g < 0 && req_valid[p] && (!req_rsp[p] || m_cnt[p] < MAXO)) g = p;
      end
    end
    obs_ready = req_ready;
    chk("req_ready", req_ready, g >= 0 ? (64'd1 << g) : 64'd0);
    m_rv = rd_data_valid;
    if (rd_data_valid) begin
      o = m_own[rd_data_tag];
      m_rp = o;
      if (m_cnt[o] == 0) m_err = 1;
      else m_cnt[o]--;
    end
    if (g >= 0) begin
      m_ptr = (g + 1) % NP;
      if (req_rsp[g]) begin
        m_own[m_tag] = g;
        inflight.push_back(m_tag);
        m_tag = (m_tag + 1) % 64;
        m_cnt[g]++;
        rsp_grants++;
      end
    end
    if (lok) begin
      m_cv = g >= 0;
      if (g >= 0) begin
        m_cmd = req_cmd[4*g +: 4];
        m_size = req_size[4*g +: 4];
        m_addr = req_addr[34*g +: 34];
      end
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 64; k++) m_own[k] = 0;
    rsp_grants = 0;
    model_reset();
    // all four ports responding: strict rotation 0,1,2,3,0
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t1_order", obs_ready, 64'd1 << order[c]);
    end
    idle();
    for (int t = 0; t < 5; t++) begin
      respond(t);
      cycle();
      chk("t1_route", rsp_port, order[t]);
    end
    idle();
    cycle();
    chk("t1_rsp_drop", rsp_valid, 0);
    // back-pressure holds payload and blocks grants
    do_reset();
    cmd_ready_out = 1'b0;
    set_port(2, 1'b0);
    cycle();
    saved_addr = addr_out;
    for (int c = 0; c < 5; c++) begin
      set_port(2, 1'b0);
      cycle();
      chk("t2_stall_ready", obs_ready, 0);
      chk("t2_stall_valid", cmd_valid_out, 1);
      chk("t2_addr_stable", addr_out, saved_addr);
    end
    cmd_ready_out = 1'b1;
    cycle();
    chk("t2_release", obs_ready, 4);
    // throttling of port 1 while port 3 keeps going
    do_reset();
    set_port(1, 1'b1);
    set_port(3, 1'b0);
    for (int c = 0; c < 6; c++) cycle();
    chk("t3_cnt_full", outstanding[1*CW +: CW], 2);
    chk("t3_p3_only", obs_ready, 8);
    respond(0);
    cycle();
    chk("t3_still_p3", obs_ready, 8);
    chk("t3_cnt_dec", outstanding[1*CW +: CW], 1);
    rd_data_valid = 1'b0;
    cycle();
    chk("t3_unblocked", obs_ready, 2);
    // non-responding command leaves the tag untouched
    do_reset();
    set_port(0, 1'b0);
    cycle();
    req_rsp[0] = 1'b1;
    cycle();
    idle();
    chk("t4_cnt", outstanding[0 +: CW], 1);
    respond(0);
    cycle();
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_port", rsp_port, 0);
    idle();
    cycle();
    chk("t4_rsp_pulse", rsp_valid, 0);
    chk("t4_cnt_zero", outstanding[0 +: CW], 0);
    // simultaneous increment and decrement on one port
    do_reset();
    set_port(2, 1'b1);
    cycle();
    respond(0);
    cycle();
    chk("t5_granted", obs_ready, 4);
    chk("t5_cnt_same", outstanding[2*CW +: CW], 1);
    // underflow is sticky until reset
    do_reset();
    set_port(3, 1'b1);
    cycle();
    idle();
    respond(0);
    cycle();
    chk("t6_no_err", err_underflow, 0);
    respond(0);
    cycle();
    chk("t6_err", err_underflow, 1);
    idle();
    for (int c = 0; c < 3; c++) cycle();
    chk("t6_err_held", err_underflow, 1);
    do_reset();
    chk("t6_err_clr", err_underflow, 0);
    // random traffic past the tag wrap
    rsp_grants = 0;
    for (int c = 0; c < 4000 && rsp_grants < 80; c++) begin
      for (int p = 0; p < NP; p++) set_port(p, 1'($urandom));
      req_valid = NP'($urandom);
      cmd_ready_out = $urandom_range(0, 3) != 0;
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) respond(inflight.pop_front());
      else rd_data_valid = 1'b0;
      cycle();
    end
    chk("t7_wrapped", rsp_grants >= 80, 1);
    idle();
    while (inflight.size() > 0) begin
      respond(inflight.pop_front());
      cycle();
    end
    idle();
    cycle();
    chk("t7_drained", outstanding, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hmc_cmd_arbiter.md
Name: hmc_cmd_arbiter

Overview:
- Shares the single HMC command port between NUM_PORTS requesters (DMA read engine, DMA write engine, user ports) using round-robin arbitration.
- Sits directly upstream of the HMC tag manager. It mirrors the manager's sequential tag allocation so each returned rd_data_tag can be steered back to the requester that issued it.
- Enforces a per-port outstanding-response limit so no single port can drain the shared tag pool.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ID_WIDTH, 6, HMC tag width; owner table depth is 2**ID_WIDTH.
- MAX_OUTSTANDING, 16, maximum responses in flight per port (1..2**ID_WIDTH).
- PORT_W, 3, width of a port index; must satisfy 2**PORT_W >= NUM_PORTS.
- CNT_W, 6, width of the per-port outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_cmd  in  4*NUM_PORTS  per-port HMC command, port i at bits [4i+3:4i].
- req_addr  in  34*NUM_PORTS  per-port address.
- req_size  in  4*NUM_PORTS  per-port size.
- req_rsp  in  NUM_PORTS  per-port flag: 1 = command generates a response.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port accept; at most one bit set in any cycle.
- cmd_out  out  4  granted command.
- addr_out  out  34  granted address.
- size_out  out  4  granted size.
- cmd_valid_out  out  1  output holds a command.
- cmd_ready_out  in  1  downstream tag manager accepts.
- rd_data_tag  in  ID_WIDTH  returned tag.
- rd_data_valid  in  1  response beat valid.
- rsp_port  out  PORT_W  owner of the last response.
- rsp_valid  out  1  rsp_port is valid this cycle.
- outstanding  out  CNT_W*NUM_PORTS  per-port in-flight count.
- err_underflow  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - cmd_valid_out=0, rsp_valid=0, err_underflow=0, all outstanding=0.
  - RR pointer=0, mirror tag=0; cmd_out, addr_out, size_out, rsp_port = 0.
  - Owner table is not reset; entries are written before they are read.
- Output register:
  - Single stage.
  - load_ok = ~cmd_valid_out | cmd_ready_out, which allows back-to-back issue at full rate.
  - cmd_valid_out is held with stable payload until cmd_ready_out.
  - If nothing is granted while cmd_ready_out=1, cmd_valid_out clears the next cycle.
- Eligibility: port i is eligible when req_valid[i] & (~req_rsp[i] | outstanding[i] < MAX_OUTSTANDING).
- Arbitration:
  - Combinational, evaluated only when load_ok.
  - Grant the first eligible port searching from the RR pointer upward, with wrap.
  - req_ready[g]=1 for the granted port only.
  - Latency: request to cmd_valid_out is 1 cycle.
  - On grant, the RR pointer moves to g+1 mod NUM_PORTS; with no grant it is unchanged.
- Tag mirror:
  - The tag manager assigns tags sequentially from 0 after reset and increments only for response-generating commands.
  - This block tracks a mirror tag counter with identical rules, advancing on grant with req_rsp set.
  - On such a grant: owner[mirror_tag] <= g, then mirror_tag <= mirror_tag+1, wrapping modulo 2**ID_WIDTH.
- Outstanding counters:
  - +1 on grant with req_rsp.
  - -1 on a response whose owner is that port.
  - Increment and decrement in the same cycle on the same port leaves the count unchanged.
- Response routing:
  - On rd_data_valid, next cycle: rsp_valid=1, rsp_port=owner[rd_data_tag].
  - 1-cycle latency, one response per cycle accepted.
- Underflow:
  - A response to a port whose count is 0 sets err_underflow (sticky until reset).
  - The count stays at 0.
- Non-response commands (req_rsp=0):
  - Are never throttled.
  - Do not touch the mirror tag or the owner table.
- Reset mid-transfer: all in-flight state is discarded. Downstream blocks are required to be reset together with this one.

Decomposition:
- Shared package hmc_arb_pkg:
  - HMC command encodings.
  - ADDR_WIDTH=34.
  - Port-index width helper function.
- One sub-module: hmc_rr_arbiter, a generic NUM_PORTS round-robin grant with pointer.
- The owner table is an inferred distributed RAM in the top level.

Test Plan:
- Reset, then ports 0..3 all valid with req_rsp=1 and cmd_ready_out=1.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles.
  - Required: mirror tags 0..4, with owner[0]=0 and owner[4]=0.
- Hold cmd_ready_out=0 for 5 cycles with port 2 valid.
  - Required: cmd_valid_out=1 with payload stable.
  - Required: req_ready=0 for all ports until cmd_ready_out=1, then the next grant follows in that same cycle.
- MAX_OUTSTANDING=2, port 1 issues 2 responding commands and keeps req_valid=1.
  - Required: port 1 is blocked while port 3 continues to be granted.
  - Required: rd_data_valid with tag 0 unblocks port 1 one cycle later (outstanding[1] 2->1).
- Port 0 issues cmd with req_rsp=0, then cmd with req_rsp=1.
  - Required: the second command gets mirror tag 0.
  - Required: outstanding[0]=1.
  - Required: response tag 0 gives rsp_port=0 and rsp_valid for 1 cycle.
- Grant with rsp on port 2 in the same cycle as a response for port 2.
  - Required: outstanding[2] is unchanged.
- Response with a tag owned by a port whose count is 0.
  - Required: err_underflow=1, held until rst_n is asserted.
- Issue 70 responding commands with responses returned.
  - Required: mirror tag wraps 63->0.
  - Required: routing remains correct after the wrap.
